ni_flit_tx: RTL and testbench

Network-interface transmitter that sits at the upstream end of a router input port. It accepts packet descriptors and payload words from a local source and segments each packet into HEAD / BODY / TAIL (or HEADTAIL) flits. It allocates a downstream virtual channel round-robin and drives flits onto the link only while the selected downstream VC buffer signals "on". This is the sending side of the valid-flit / on-off / allocatable-VC protocol that the router input port receives.

---
 rtl/ni_flit_tx_pkg.sv | 16 +
 rtl/noc_params.sv | 36 +++
 rtl/ni_flit_tx_if.sv | 35 +++
 rtl/vc_select_rr.sv | 32 +++
 rtl/ni_flit_tx.sv | 140 ++++++++++++++
 tb/tb_ni_flit_tx.sv | 276 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/ni_flit_tx_pkg.sv
// Transmitter-local FSM state type and VC index helper.
package ni_flit_tx_pkg;
    import noc_params::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        SEND  = 2'd2
    } tx_state_t;

    // Next round-robin start position after a grant, wrapping at VC_NUM.
    function automatic logic [VC_SIZE-1:0] vc_wrap_inc(input logic [VC_SIZE-1:0] v);
        return (int'(v) == VC_NUM - 1) ? '0 : v + VC_SIZE'(1);
    endfunction

endpackage

// File: rtl/noc_params.sv
// Shared NoC link parameters and flit layout used by the network interface and router ports.
package noc_params;

    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    // Head and body/tail flits share the same data field width.
    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

endpackage

// File: rtl/ni_flit_tx_if.sv
// Local source + downstream link bundle for the flit transmitter.
interface ni_flit_tx_if
    import noc_params::*;
#(
    parameter int LEN_W = 4
) ();

    logic                         pkt_valid_i;
    logic                         pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
    logic [LEN_W-1:0]             pkt_len_i;
    logic                         pl_valid_i;
    logic                         pl_ready_o;
    logic [FLIT_DATA_SIZE-1:0]    pl_data_i;
    logic [VC_NUM-1:0]            on_off_i;
    logic [VC_NUM-1:0]            is_allocatable_vc_i;
    flit_t                        data_o;
    logic                         valid_flit_o;
    logic                         err_o;

    modport master (
        input  pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_head_pl_i, pkt_len_i,
        input  pl_valid_i, pl_data_i, on_off_i, is_allocatable_vc_i,
        output pkt_ready_o, pl_ready_o, data_o, valid_flit_o, err_o
    );

    modport slave (
        output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_head_pl_i, pkt_len_i,
        output pl_valid_i, pl_data_i, on_off_i, is_allocatable_vc_i,
        input  pkt_ready_o, pl_ready_o, data_o, valid_flit_o, err_o
    );

endinterface

// File: rtl/vc_select_rr.sv
// Combinational round-robin picker: first set bit of eligible at or above rr_ptr, wrapping.
module vc_select_rr #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant
);

    logic [N-1:0] rot;
    logic [W-1:0] idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign idx[gi] = W'((int'(rr_ptr) + gi) % N);
            assign rot[gi] = eligible[idx[gi]];
        end
    endgenerate

    // Scan downward so the lowest rotated position (closest to rr_ptr) wins.
    always_comb begin
        grant_valid = |rot;
        grant       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) grant = idx[i];
        end
    end

endmodule

// File: rtl/ni_flit_tx.sv
// NI transmitter: segments descriptors + payload words into flits, allocates a downstream
// VC round-robin and sends only while that VC signals on.
module ni_flit_tx
    import noc_params::*;
    import ni_flit_tx_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 8,
    parameter int LEN_W         = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    ni_flit_tx_if.master bus
);

    tx_state_t                    state_reg;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest_reg;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest_reg;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl_reg;
    logic [LEN_W-1:0]             len_reg;
    logic [LEN_W-1:0]             remaining_reg;
    logic [VC_SIZE-1:0]           rr_ptr_reg;
    logic [VC_SIZE-1:0]           cur_vc_reg;
    logic [VC_NUM-1:0]            pending_reg;
    flit_t                        data_reg;
    logic                         valid_reg;
    logic                         err_reg;

    logic [VC_NUM-1:0]  eligible;
    logic               grant_valid;
    logic [VC_SIZE-1:0] grant;
    logic [LEN_W-1:0]   len_fixed;
    logic               len_bad;
    flit_t              head_flit;
    flit_t              body_flit;

    // Pending blocks a VC we just granted until downstream shows it as non-allocatable.
    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_elig
            assign eligible[gi] = bus.is_allocatable_vc_i[gi] & bus.on_off_i[gi] & ~pending_reg[gi];
        end
    endgenerate

    vc_select_rr #(
        .N (VC_NUM),
        .W (VC_SIZE)
    ) u_vc_select (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        len_fixed = bus.pkt_len_i;
        len_bad   = 1'b0;
        if (bus.pkt_len_i == '0) begin
            len_fixed = LEN_W'(1);
            len_bad   = 1'b1;
        end else if (bus.pkt_len_i > LEN_W'(MAX_PKT_FLITS)) begin
            len_fixed = LEN_W'(MAX_PKT_FLITS);
            len_bad   = 1'b1;
        end
    end

    always_comb begin
        head_flit                        = '0;
        head_flit.flit_label             = (len_reg == LEN_W'(1)) ? HEADTAIL : HEAD;
        head_flit.vc_id                  = grant;
        head_flit.data.head_data.x_dest  = x_dest_reg;
        head_flit.data.head_data.y_dest  = y_dest_reg;
        head_flit.data.head_data.head_pl = head_pl_reg;

        body_flit            = '0;
        body_flit.flit_label = (remaining_reg > LEN_W'(1)) ? BODY : TAIL;
        body_flit.vc_id      = cur_vc_reg;
        body_flit.data.bt_pl = bus.pl_data_i;
    end

    assign bus.pkt_ready_o  = (state_reg == IDLE);
    assign bus.pl_ready_o   = (state_reg == SEND) && bus.on_off_i[cur_vc_reg];
    assign bus.data_o       = data_reg;
    assign bus.valid_flit_o = valid_reg;
    assign bus.err_o        = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_dest_reg    <= '0;
            y_dest_reg    <= '0;
            head_pl_reg   <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
            rr_ptr_reg    <= '0;
            cur_vc_reg    <= '0;
            pending_reg   <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            // A grant below overrides this clear for the granted bit.
            pending_reg <= pending_reg & bus.is_allocatable_vc_i;
            case (state_reg)
                IDLE: begin
                    if (bus.pkt_valid_i) begin
                        x_dest_reg  <= bus.pkt_x_dest_i;
                        y_dest_reg  <= bus.pkt_y_dest_i;
                        head_pl_reg <= bus.pkt_head_pl_i;
                        len_reg     <= len_fixed;
                        err_reg     <= len_bad;
                        state_reg   <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (grant_valid) begin
                        data_reg           <= head_flit;
                        valid_reg          <= 1'b1;
                        pending_reg[grant] <= 1'b1;
                        rr_ptr_reg         <= vc_wrap_inc(grant);
                        cur_vc_reg         <= grant;
                        remaining_reg      <= len_reg - LEN_W'(1);
                        state_reg          <= (len_reg == LEN_W'(1)) ? IDLE : SEND;
                    end
                end
                SEND: begin
                    if (bus.pl_valid_i && bus.on_off_i[cur_vc_reg]) begin
                        data_reg      <= body_flit;
                        valid_reg     <= 1'b1;
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1)) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_flit_tx.sv
// Directed bench for ni_flit_tx: flits are collected by a negedge monitor and compared to hand-built values.
module tb_ni_flit_tx;
    import noc_params::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   err_cnt;
    int   err_cyc;
    int   hs;
    int   mark;

    flit_t               rx_q[$];
    int                  rx_cyc[$];
    logic [15:0]         pl_q[$];

    ni_flit_tx_if #(.LEN_W(4)) bus ();

    ni_flit_tx #(.MAX_PKT_FLITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid_flit_o) begin
            rx_q.push_back(bus.data_o);
            rx_cyc.push_back(cyc);
            $display("flit cyc=%0d label=%0d vc=%0d data=%04h", cyc,
                     bus.data_o.flit_label, bus.data_o.vc_id, bus.data_o.data.bt_pl);
        end
        if (bus.err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Payload source: pops a word on each observed handshake.
    initial begin
        logic hs_pl;
        bus.pl_valid_i = 1'b0;
        bus.pl_data_i  = '0;
        forever begin
            @(posedge clk);
            hs_pl = bus.pl_valid_i && bus.pl_ready_o;
            #1;
            if (hs_pl && pl_q.size() > 0) void'(pl_q.pop_front());
            bus.pl_valid_i = (pl_q.size() > 0);
            bus.pl_data_i  = (pl_q.size() > 0) ? pl_q[0] : 16'h0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_flit(input flit_label_t l, input int vc, input logic [15:0] d);
        flit_t f;
        f            = '0;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.data.bt_pl = d;
        return 32'(f);
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return 32'(rx_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < rx_cyc.size()) return rx_cyc[i];
        return -1000;
    endfunction

    task automatic rx_clear();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic send_desc(input int x, input int y, input int hp, input int len, output int hs_cyc);
        bit ok;
        @(posedge clk); #1;
        bus.pkt_x_dest_i  = 4'(x);
        bus.pkt_y_dest_i  = 4'(y);
        bus.pkt_head_pl_i = 8'(hp);
        bus.pkt_len_i     = 4'(len);
        bus.pkt_valid_i   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.pkt_ready_o) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.pkt_valid_i = 1'b0;
        hs_cyc = cyc;
        check("desc_handshake", 32'(ok), 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk); #1;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic clear_pending();
        @(negedge clk); #1 bus.is_allocatable_vc_i = '0;
        @(negedge clk); #1 bus.is_allocatable_vc_i = '1;
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        err_cnt  = 0;
        err_cyc  = -1;
        rst      = 1'b1;
        bus.pkt_valid_i         = 1'b0;
        bus.pkt_x_dest_i        = '0;
        bus.pkt_y_dest_i        = '0;
        bus.pkt_head_pl_i       = '0;
        bus.pkt_len_i           = '0;
        bus.on_off_i            = '1;
        bus.is_allocatable_vc_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.valid_flit_o), 32'd0);
        check("rst_pkt_ready", 32'(bus.pkt_ready_o), 32'd1);
        check("rst_pl_ready", 32'(bus.pl_ready_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        #1 rst = 1'b0;

        // Single-flit packets: vc 0 then vc 1
        rx_clear();
        send_desc(2, 3, 8'h5A, 1, hs);
        wait_rx("single_cnt", 1, 20);
        check("single_flit", rx_at(0), mk_flit(HEADTAIL, 0, 16'h235A));
        check("single_latency", 32'(cyc_at(0) - hs), 32'd1);
        send_desc(4, 5, 8'h00, 1, hs);
        wait_rx("single2_cnt", 2, 20);
        check("single2_flit", rx_at(1), mk_flit(HEADTAIL, 1, 16'h4500));
        check("single_err", 32'(err_cnt), 32'd0);
        clear_pending();

        // Four-flit packet at full throughput on vc 2
        rx_clear();
        pl_q = '{16'h00A1, 16'h00A2, 16'h00A3};
        send_desc(1, 0, 8'h11, 4, hs);
        wait_rx("four_cnt", 4, 30);
        check("four_head", rx_at(0), mk_flit(HEAD, 2, 16'h1011));
        check("four_body1", rx_at(1), mk_flit(BODY, 2, 16'h00A1));
        check("four_body2", rx_at(2), mk_flit(BODY, 2, 16'h00A2));
        check("four_tail", rx_at(3), mk_flit(TAIL, 2, 16'h00A3));
        check("four_back_to_back", 32'(cyc_at(3) - cyc_at(0)), 32'd3);
        check("four_idle_after_tail", 32'(bus.pkt_ready_o), 32'd1);
        clear_pending();

        // Stall on vc 3 for three cycles after the first BODY
        rx_clear();
        pl_q = '{16'h00B1, 16'h00B2, 16'h00B3};
        send_desc(6, 7, 8'h22, 4, hs);
        wait_rx("stall_pre_cnt", 2, 30);
        bus.on_off_i[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_pl_ready", 32'(bus.pl_ready_o), 32'd0);
            @(negedge clk);
        end
        #1 check("stall_no_flits", rx_q.size(), 32'd2);
        bus.on_off_i = '1;
        wait_rx("stall_cnt", 4, 30);
        check("stall_head", rx_at(0), mk_flit(HEAD, 3, 16'h6722));
        check("stall_body1", rx_at(1), mk_flit(BODY, 3, 16'h00B1));
        check("stall_body2", rx_at(2), mk_flit(BODY, 3, 16'h00B2));
        check("stall_tail", rx_at(3), mk_flit(TAIL, 3, 16'h00B3));
        check("stall_gap", 32'(cyc_at(2) - cyc_at(1)), 32'd4);
        check("stall_resume", 32'(cyc_at(3) - cyc_at(2)), 32'd1);
        clear_pending();

        // Allocation waits, then pending masking and clearing
        rx_clear();
        bus.is_allocatable_vc_i = '0;
        send_desc(3, 3, 8'h33, 1, hs);
        repeat (5) @(negedge clk);
        check("alloc_wait_no_flit", rx_q.size(), 32'd0);
        check("alloc_wait_busy", 32'(bus.pkt_ready_o), 32'd0);
        #1 bus.is_allocatable_vc_i = 4'b0100;
        mark = cyc;
        wait_rx("alloc_cnt", 1, 20);
        check("alloc_vc2", rx_at(0), mk_flit(HEADTAIL, 2, 16'h3333));
        check("alloc_latency", 32'(cyc_at(0) - mark), 32'd1);
        bus.is_allocatable_vc_i = '1;
        send_desc(3, 4, 8'h44, 1, hs);
        wait_rx("pend_cnt", 2, 20);
        check("pend_skip_vc2", rx_at(1), mk_flit(HEADTAIL, 3, 16'h3444));
        bus.on_off_i = 4'b0100;
        send_desc(5, 5, 8'h55, 1, hs);
        repeat (4) @(negedge clk);
        check("pend_blocked", rx_q.size(), 32'd2);
        #1 bus.is_allocatable_vc_i[2] = 1'b0;
        @(negedge clk);
        #1 bus.is_allocatable_vc_i[2] = 1'b1;
        wait_rx("pend_clear_cnt", 3, 20);
        check("pend_cleared_vc2", rx_at(2), mk_flit(HEADTAIL, 2, 16'h5555));
        bus.on_off_i = '1;
        check("alloc_err", 32'(err_cnt), 32'd0);
        clear_pending();

        // Illegal lengths
        rx_clear();
        send_desc(7, 1, 8'h66, 0, hs);
        wait_rx("len0_cnt", 1, 20);
        check("len0_flit", rx_at(0), mk_flit(HEADTAIL, 3, 16'h7166));
        check("len0_err_cnt", 32'(err_cnt), 32'd1);
        check("len0_err_timing", 32'(err_cyc - hs), 32'd0);
        clear_pending();
        rx_clear();
        pl_q = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4, 16'h00C5, 16'h00C6, 16'h00C7};
        send_desc(8, 9, 8'h77, 9, hs);
        wait_rx("len9_cnt", 8, 40);
        repeat (10) @(negedge clk);
        check("len9_exact8", rx_q.size(), 32'd8);
        check("len9_err_cnt", 32'(err_cnt), 32'd2);
        check("len9_head", rx_at(0), mk_flit(HEAD, 0, 16'h8977));
        check("len9_body", rx_at(1), mk_flit(BODY, 0, 16'h00C1));
        check("len9_tail", rx_at(7), mk_flit(TAIL, 0, 16'h00C7));
        check("len9_payload_used", pl_q.size(), 32'd0);
        clear_pending();

        // Reset mid-packet
        rx_clear();
        pl_q = '{16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4, 16'h00D5};
        send_desc(0, 0, 8'h88, 6, hs);
        wait_rx("rst_mid_cnt", 2, 30);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.valid_flit_o), 32'd0);
        check("rst_mid_pkt_ready", 32'(bus.pkt_ready_o), 32'd1);
        check("rst_mid_pl_ready", 32'(bus.pl_ready_o), 32'd0);
        check("rst_mid_data", 32'(bus.data_o), 32'd0);
        pl_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_more", rx_q.size(), 32'd2);
        send_desc(0, 1, 8'h99, 1, hs);
        wait_rx("rst_post_cnt", 3, 20);
        check("rst_post_rr", rx_at(2), mk_flit(HEADTAIL, 0, 16'h0199));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
